skew_collector: RTL and testbench
=================================

SKEW_COLLECTOR -- requirements
Module: skew_collector

Interface
REQ-001 SHALL have parameter data_size, default 16, width of one fixed-point element.
REQ-002 SHALL have parameter size, default 3, number of lanes (systolic columns) and rows per layer.
REQ-003 SHALL have parameter fifo_depth, default 4, output FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  lane 0 of a new skewed row is present this cycle.
REQ-007 in_stream  input  data_size*size  skewed lanes; lane c at bits [data_size*(size-c)-1 -: data_size].
REQ-008 start_new_layer  input  1  sampled with in_valid; marks that row as row 0 of a layer.
REQ-009 out_data  output  data_size*size  de-skewed row, same lane packing as in_stream.
REQ-010 out_valid  output  1  FIFO head holds a row.
REQ-011 out_ready  input  1  consumer accepts the head row this cycle.
REQ-012 out_row  output  $clog2(size) (minimum 1)  row index of the head row within its layer.
REQ-013 out_last  output  1  head row index equals size-1.
REQ-014 overflow  output  1  sticky flag for a dropped row.

Function
REQ-015 Lane c of row r SHALL arrive exactly c cycles after lane 0 of row r; lane 0 arrives in the cycle in_valid is high.
REQ-016 Lane c SHALL be delayed by size-1-c registers; lane size-1 SHALL pass with zero added delay.
REQ-017 in_valid and the row index SHALL travel through a size-1 stage pipeline matched to the lane-0 delay.
REQ-018 The aligned row SHALL be pushed at the clock edge ending cycle t+size-1 (t = lane-0 cycle); with an empty FIFO, out_valid SHALL rise in cycle t+size (latency size).
REQ-019 Back-to-back in_valid SHALL be sustained at one row per cycle with no bubbles.
REQ-020 Row index counter: a row sampled with start_new_layer=1 SHALL take index 0; otherwise it takes the previous index +1, wrapping from size-1 to 0; the counter advances only on in_valid.
REQ-021 The FIFO SHALL store data, row index and last bit per entry and present the head combinationally on out_data, out_row and out_last.
REQ-022 A pop SHALL occur when out_valid and out_ready are both 1; out_ready while out_valid=0 SHALL have no effect.
REQ-023 When the FIFO is full, a push in the same cycle as a pop SHALL be accepted and the occupancy SHALL stay full.
REQ-024 When the FIFO is full and no pop occurs, a push SHALL drop the incoming row; FIFO contents SHALL be unchanged and the row counter SHALL still advance.
REQ-025 Pointers SHALL wrap modulo fifo_depth; full and empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-026 out_data SHALL be 0 whenever out_valid=0.
REQ-027 No arithmetic SHALL be applied to lane data; element bits SHALL pass unmodified.

Reset
REQ-028 rst_n=0 SHALL immediately clear all delay registers, the valid pipeline, the row counter, the FIFO pointers and overflow.
REQ-029 During and after reset, out_valid, out_data, out_row, out_last and overflow SHALL be 0.
REQ-030 Reset in the middle of a row SHALL discard the partial row; the first in_valid after release SHALL start a fresh row with index 0.

Configuration
REQ-031 Macro SKEW_COLLECTOR_OVERFLOW_EN: when defined, overflow SHALL set on any drop under REQ-024 and hold until reset.
REQ-032 When SKEW_COLLECTOR_OVERFLOW_EN is undefined, overflow SHALL be tied to 0 and drops SHALL still occur silently.

Verification
REQ-033 size=3, out_ready=1. Drive one row: lane0=1 at cycle 0, lane1=2 at cycle 1, lane2=3 at cycle 2, with start_new_layer=1. Required: out_valid in cycle 3 only, out_data lanes {1,2,3}, out_row=0, out_last=0.
REQ-034 Drive rows {1,2,3}, {4,5,6} and {7,8,9} in skewed form with in_valid high for cycles 0..2. Required: three consecutive out_valid cycles 3..5 with out_row 0,1,2 and out_last only on {7,8,9}.
REQ-035 fifo_depth=4, out_ready=0, six back-to-back rows. Required: four rows retained and occupancy full; overflow=1 with the macro defined, 0 without; then out_ready=1 pops the first four rows in order.
REQ-036 Keep the FIFO full and assert out_ready in the same cycle a push lands. Required: the pushed row is kept, the head advances and overflow stays 0.
REQ-037 Assert rst_n=0 one cycle after lane 0 of a row. Required: outputs go to 0 immediately and no out_valid appears for that row.
REQ-038 Assert start_new_layer on the second row of a layer. Required: that row reports out_row=0 and the following row reports out_row=1.

Source files
------------

// File: rtl/skew_collector.sv
`default_nettype none
// ============================================================================
// Module      : skew_collector
// Description : Collects a diagonally skewed systolic output stream, de-skews
//               it into aligned rows, tags each row with its index inside the
//               current layer and buffers rows in a small output FIFO.
//               Optional macro SKEW_COLLECTOR_OVERFLOW_EN enables a sticky
//               overflow flag for rows dropped while the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_collector #(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int fifo_depth = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [data_size*size-1:0]                     in_stream,
    input  logic                                          start_new_layer,
    output logic [data_size*size-1:0]                     out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [((size > 1) ? $clog2(size) : 1)-1:0]    out_row,
    output logic                                          out_last,
    output logic                                          overflow
);

    localparam int ROW_W = (size > 1) ? $clog2(size) : 1;
    localparam int PTR_W = $clog2(fifo_depth);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(size - 1);

    // ------------------------------------------------------------------
    // Row index assignment at the input
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] next_idx;
    logic [ROW_W-1:0] cur_idx;

    // Index this cycle's row would take if in_valid is high
    always_comb begin
        cur_idx = start_new_layer ? '0 : next_idx;
    end

    // Counter holds the index of the next row; reset makes the first row 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_idx <= '0;
        end else if (in_valid) begin
            next_idx <= (cur_idx == LAST_ROW) ? '0 : cur_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane de-skew: lane c waits size-1-c cycles, last lane is live
    // ------------------------------------------------------------------
    logic [data_size*size-1:0] aligned;

    for (genvar c = 0; c < size; c++) begin : g_lane
        localparam int DEPTH = size - 1 - c;
        localparam int HI    = data_size*(size-c) - 1;
        if (DEPTH == 0) begin : g_pass
            assign aligned[HI -: data_size] = in_stream[HI -: data_size];
        end else begin : g_delay
            logic [data_size-1:0] taps [DEPTH];
            // Shift register delaying this lane to line up with the last lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
                end else begin
                    taps[0] <= in_stream[HI -: data_size];
                    for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
                end
            end
            assign aligned[HI -: data_size] = taps[DEPTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Valid / row-index pipeline matched to the lane-0 delay
    // ------------------------------------------------------------------
    logic             push_valid;
    logic [ROW_W-1:0] push_row;

    if (size > 1) begin : g_pipe
        logic             vld_q [size-1];
        logic [ROW_W-1:0] row_q [size-1];
        // Carry the row's valid flag and index alongside its lane-0 data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < size-1; k++) begin
                    vld_q[k] <= 1'b0;
                    row_q[k] <= '0;
                end
            end else begin
                vld_q[0] <= in_valid;
                row_q[0] <= cur_idx;
                for (int k = 1; k < size-1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    row_q[k] <= row_q[k-1];
                end
            end
        end
        assign push_valid = vld_q[size-2];
        assign push_row   = row_q[size-2];
    end else begin : g_nopipe
        assign push_valid = in_valid;
        assign push_row   = cur_idx;
    end

    // ------------------------------------------------------------------
    // Output FIFO with an extra pointer bit to tell full from empty
    // ------------------------------------------------------------------
    logic [PTR_W:0]            wr_ptr;
    logic [PTR_W:0]            rd_ptr;
    logic [data_size*size-1:0] mem_data [fifo_depth];
    logic [ROW_W-1:0]          mem_row  [fifo_depth];
    logic                      mem_last [fifo_depth];
    logic                      empty;
    logic                      full;
    logic                      pop;
    logic                      push_ok;

    // Full/empty decode and handshake; a pop frees the slot a full-FIFO push needs
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop     = !empty && out_ready;
        push_ok = push_valid && (!full || pop);
    end

    // Pointer update; a rejected push leaves the write pointer alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are qualified by the pointers so need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr[PTR_W-1:0]] <= aligned;
            mem_row[wr_ptr[PTR_W-1:0]]  <= push_row;
            mem_last[wr_ptr[PTR_W-1:0]] <= (push_row == LAST_ROW);
        end
    end

    // Head presented combinationally, forced to zero when nothing is held
    always_comb begin
        out_valid = !empty;
        out_data  = '0;
        out_row   = '0;
        out_last  = 1'b0;
        if (!empty) begin
            out_data = mem_data[rd_ptr[PTR_W-1:0]];
            out_row  = mem_row[rd_ptr[PTR_W-1:0]];
            out_last = mem_last[rd_ptr[PTR_W-1:0]];
        end
    end

`ifdef SKEW_COLLECTOR_OVERFLOW_EN
    logic drop;
    logic overflow_q;

    // A row is lost when it arrives at a full FIFO that is not popping
    always_comb begin
        drop = push_valid && full && !pop;
    end

    // Sticky record of any lost row, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_skew_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_collector
// Description : Directed self-checking bench for skew_collector (size=3,
//               data_size=16, fifo_depth=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_collector;

    localparam int DW   = 16;
    localparam int SIZE = 3;
    localparam int DEP  = 4;
    localparam int W    = DW*SIZE;

`ifdef SKEW_COLLECTOR_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_stream;
    logic         start_new_layer;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_row;
    logic         out_last;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // stimulus tables and per-cycle observation logs
    logic [DW-1:0] rows [0:7][0:SIZE-1];
    logic          st   [0:7];
    logic          rdy  [0:15];
    logic          ov   [0:15];
    logic [W-1:0]  od   [0:15];
    logic [1:0]    orow [0:15];
    logic          ol   [0:15];
    logic          oovf [0:15];

    skew_collector #(
        .data_size (DW),
        .size      (SIZE),
        .fifo_depth(DEP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_stream      (in_stream),
        .start_new_layer(start_new_layer),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .out_last       (out_last),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input int r);
        return {rows[r][0], rows[r][1], rows[r][2]};
    endfunction

    task automatic fill_rows(input int base);
        for (int r = 0; r < 8; r++) begin
            st[r] = 1'b0;
            for (int c = 0; c < SIZE; c++) rows[r][c] = DW'(base + r*16 + c);
        end
    endtask

    task automatic set_rdy(input logic v);
        for (int k = 0; k < 16; k++) rdy[k] = v;
    endtask

    // Drive n skewed rows starting at cycle 0 and log outputs each cycle
    task automatic run(input int n, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            in_valid        = (k < n);
            start_new_layer = (k < n) ? st[k] : 1'b0;
            for (int c = 0; c < SIZE; c++) begin
                if ((k - c) >= 0 && (k - c) < n)
                    in_stream[DW*(SIZE-c)-1 -: DW] = rows[k-c][c];
                else
                    in_stream[DW*(SIZE-c)-1 -: DW] = '0;
            end
            out_ready = rdy[k];
            #1;
            ov[k]   = out_valid;
            od[k]   = out_data;
            orow[k] = out_row;
            ol[k]   = out_last;
            oovf[k] = overflow;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_row !== 2'd0 ||
            out_last !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_during: valid=%b data=%h row=%0d last=%b ovf=%b, required all 0",
                     out_valid, out_data, out_row, out_last, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: valid=%b data=%h ovf=%b, required 0",
                     out_valid, out_data, overflow);
        end
    endtask

    task automatic test_single();
        fill_rows(0);
        rows[0][0] = 16'd1; rows[0][1] = 16'd2; rows[0][2] = 16'd3;
        st[0] = 1'b1;
        set_rdy(1'b1);
        run(1, 6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (ov[k] !== (k == 3)) begin
                errors++;
                $display("FAIL single_valid cycle %0d: got %b, required %b", k, ov[k], (k == 3));
            end
        end
        checks++;
        if (od[3] !== 48'h0001_0002_0003 || orow[3] !== 2'd0 || ol[3] !== 1'b0) begin
            errors++;
            $display("FAIL single_row: data=%h row=%0d last=%b, required 000100020003 row=0 last=0",
                     od[3], orow[3], ol[3]);
        end
        checks++;
        if (od[4] !== '0) begin
            errors++;
            $display("FAIL single_zero_data: got %h, required 0", od[4]);
        end
    endtask

    task automatic test_back_to_back();
        fill_rows(0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < SIZE; c++) rows[r][c] = DW'(r*3 + c + 1);
        st[0] = 1'b1;
        set_rdy(1'b1);
        run(3, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ov[k] !== (k >= 3 && k <= 5)) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d: got %b, required %b", k, ov[k], (k >= 3 && k <= 5));
            end
        end
        checks++;
        if (od[3] !== 48'h0001_0002_0003 || od[4] !== 48'h0004_0005_0006 ||
            od[5] !== 48'h0007_0008_0009) begin
            errors++;
            $display("FAIL b2b_data: got %h %h %h, required 000100020003 000400050006 000700080009",
                     od[3], od[4], od[5]);
        end
        checks++;
        if (orow[3] !== 2'd0 || orow[4] !== 2'd1 || orow[5] !== 2'd2 ||
            ol[3] !== 1'b0 || ol[4] !== 1'b0 || ol[5] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_row: rows=%0d,%0d,%0d last=%b%b%b, required rows 0,1,2 last 001",
                     orow[3], orow[4], orow[5], ol[3], ol[4], ol[5]);
        end
    endtask

    task automatic test_new_layer();
        fill_rows(16'h200);
        st[0] = 1'b1;
        st[1] = 1'b1;
        set_rdy(1'b1);
        run(3, 8);
        checks++;
        if (orow[3] !== 2'd0 || orow[4] !== 2'd0 || orow[5] !== 2'd1 ||
            ol[5] !== 1'b0 || od[4] !== pk(1)) begin
            errors++;
            $display("FAIL new_layer: rows=%0d,%0d,%0d last3=%b data1=%h, required rows 0,0,1 last 0 data %h",
                     orow[3], orow[4], orow[5], ol[5], od[4], pk(1));
        end
    endtask

    task automatic test_full_push_pop();
        fill_rows(16'h100);
        st[0] = 1'b1;
        set_rdy(1'b0);
        rdy[6] = 1'b1;
        run(5, 8);
        checks++;
        if (ov[6] !== 1'b1 || od[6] !== pk(0) || ov[7] !== 1'b1 || od[7] !== pk(1)) begin
            errors++;
            $display("FAIL fullpp_head: c6 %b/%h c7 %b/%h, required 1/%h 1/%h",
                     ov[6], od[6], ov[7], od[7], pk(0), pk(1));
        end
        checks++;
        if (oovf[7] !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_ovf: got %b, required 0", oovf[7]);
        end
        set_rdy(1'b1);
        run(0, 6);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || od[k] !== pk(k + 1) || orow[k] !== 2'((k + 1) % 3)) begin
                errors++;
                $display("FAIL fullpp_drain %0d: valid=%b data=%h row=%0d, required 1 %h %0d",
                         k, ov[k], od[k], orow[k], pk(k + 1), (k + 1) % 3);
            end
        end
        checks++;
        if (ov[4] !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_empty: got %b, required 0", ov[4]);
        end
    endtask

    task automatic test_overflow();
        fill_rows(16'h300);
        st[0] = 1'b1;
        set_rdy(1'b0);
        run(6, 9);
        checks++;
        if (ov[8] !== 1'b1 || od[8] !== pk(0)) begin
            errors++;
            $display("FAIL ovf_head: valid=%b data=%h, required 1 %h", ov[8], od[8], pk(0));
        end
        checks++;
        if (oovf[8] !== EXP_OVF) begin
            errors++;
            $display("FAIL ovf_flag: got %b, required %b", oovf[8], EXP_OVF);
        end
        set_rdy(1'b1);
        run(0, 6);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || od[k] !== pk(k) || orow[k] !== 2'(k % 3) ||
                ol[k] !== (k == 2)) begin
                errors++;
                $display("FAIL ovf_drain %0d: valid=%b data=%h row=%0d last=%b, required 1 %h %0d %b",
                         k, ov[k], od[k], orow[k], ol[k], pk(k), k % 3, (k == 2));
            end
        end
        checks++;
        if (ov[4] !== 1'b0 || oovf[5] !== EXP_OVF) begin
            errors++;
            $display("FAIL ovf_after_drain: valid=%b ovf=%b, required 0 %b", ov[4], oovf[5], EXP_OVF);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        fill_rows(16'h400);
        st[0] = 1'b1;
        set_rdy(1'b0);
        run(1, 4);
        checks++;
        if (ov[3] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_prefill: got %b, required 1", ov[3]);
        end
        @(posedge clk);
        #1;
        in_valid        = 1'b1;
        start_new_layer = 1'b0;
        in_stream       = {16'h00AA, 16'h0000, 16'h0000};
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_stream = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_row !== 2'd0 ||
            out_last !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate: valid=%b data=%h row=%0d last=%b ovf=%b, required all 0",
                     out_valid, out_data, out_row, out_last, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ghost: out_valid seen=%b, required 0", seen);
        end
        fill_rows(16'h500);
        set_rdy(1'b1);
        run(1, 6);
        checks++;
        if (ov[3] !== 1'b1 || od[3] !== pk(0) || orow[3] !== 2'd0) begin
            errors++;
            $display("FAIL midrst_fresh: valid=%b data=%h row=%0d, required 1 %h 0",
                     ov[3], od[3], orow[3], pk(0));
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_stream       = '0;
        start_new_layer = 1'b0;
        out_ready       = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_new_layer();
        test_full_push_pop();
        test_overflow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
